// File: rtl/debug_dump_tx_pkg.sv
// Shared definitions for the debug dump transmitter: state encodings,
// frame header byte and frame-length helpers used by host tooling.
package debug_dump_tx_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_HDR     = 4'd1,
        S_PC      = 4'd2,
        S_CYC     = 4'd3,
        S_REG_REQ = 4'd4,
        S_REG_LD  = 4'd5,
        S_MEM_REQ = 4'd6,
        S_MEM_LD  = 4'd7,
        S_SEND    = 4'd8,
        S_WAIT    = 4'd9,
        S_DONE    = 4'd10
    } dump_state_e;

    localparam logic [7:0] DUMP_HEADER = 8'hD0;

    // Header byte, PC word, cycle word, register file, data memory.
    function automatic int frame_bytes(int bytes_per_word, int n_regs, int n_mem);
        return 1 + 2 * bytes_per_word + bytes_per_word * (n_regs + n_mem);
    endfunction

    localparam int FRAME_BYTES = frame_bytes(4, 32, 32);

endpackage

// File: rtl/debug_dump_tx_serializer.sv
// Word-to-byte serializer: holds one word, presents its top byte and
// shifts left one byte per completed transfer, counting bytes left.
module word_byte_serializer #(
    parameter int NB_WORD = 32,
    parameter int NB_DATA = 8,
    parameter int CNT_W   = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [NB_WORD-1:0] word_i,
    input  logic [CNT_W-1:0]   nbytes_i,
    input  logic               shift_i,
    output logic [NB_DATA-1:0] byte_o,
    output logic               last_o
);

    logic [NB_WORD-1:0] shreg_q;
    logic [CNT_W-1:0]   cnt_q;

    // Load a fresh word or advance to the next byte (MSB-first).
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load_i) begin
            shreg_q <= word_i;
            cnt_q   <= nbytes_i;
        end else if (shift_i) begin
            shreg_q <= shreg_q << NB_DATA;
            cnt_q   <= cnt_q - 1'b1;
        end
    end

    assign byte_o = shreg_q[NB_WORD-1 -: NB_DATA];
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: streams header, PC, cycle count, register file
// and data memory to the UART TX, one byte per start/done handshake.
module debug_dump_tx
    import debug_dump_tx_pkg::*;
#(
    parameter int               NB_DATA     = 8,
    parameter int               NB_WORD     = 32,
    parameter int               N_REGS      = 32,
    parameter int               NB_REG_ADDR = 5,
    parameter int               N_MEM_WORDS = 32,
    parameter int               NB_MEM_ADDR = 5,
    parameter int               NB_STATE    = 4,
    parameter logic [NB_DATA-1:0] HEADER    = DUMP_HEADER
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [NB_WORD-1:0]     i_pc,
    input  logic [NB_WORD-1:0]     i_cycle_count,
    output logic [NB_REG_ADDR-1:0] o_reg_addr,
    input  logic [NB_WORD-1:0]     i_reg_data,
    output logic [NB_MEM_ADDR-1:0] o_mem_addr,
    input  logic [NB_WORD-1:0]     i_mem_data,
    output logic [NB_DATA-1:0]     o_tx_data,
    output logic                   o_tx_start,
    input  logic                   i_tx_done,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int BPW   = NB_WORD / NB_DATA;
    localparam int CNT_W = $clog2(BPW + 1);
    localparam int IDX_W = (NB_REG_ADDR > NB_MEM_ADDR) ? NB_REG_ADDR : NB_MEM_ADDR;

    logic [NB_STATE-1:0] state_q, ret_q;
    logic [NB_WORD-1:0]  pc_q, cyc_q;
    logic [IDX_W-1:0]    idx_q;
    logic                ld_wait_q;

    logic                ser_load, ser_shift, ser_last;
    logic [NB_WORD-1:0]  ser_word;
    logic [CNT_W-1:0]    ser_nbytes;
    logic [NB_DATA-1:0]  ser_byte;

    // The first WAIT cycle coincides with o_tx_start; a done pulse there is not a completion.
    assign ser_shift = (state_q == S_WAIT) && i_tx_done && !o_tx_start;

    // Select which word the serializer loads in the current phase.
    always_comb begin
        ser_load   = 1'b0;
        ser_word   = '0;
        ser_nbytes = CNT_W'(BPW);
        case (state_q)
            S_HDR: begin
                ser_load   = 1'b1;
                ser_word   = {HEADER, {(NB_WORD-NB_DATA){1'b0}}};
                ser_nbytes = CNT_W'(1);
            end
            S_PC: begin
                ser_load = 1'b1;
                ser_word = pc_q;
            end
            S_CYC: begin
                ser_load = 1'b1;
                ser_word = cyc_q;
            end
            S_REG_LD: begin
                ser_load = ld_wait_q;
                ser_word = i_reg_data;
            end
            S_MEM_LD: begin
                ser_load = ld_wait_q;
                ser_word = i_mem_data;
            end
            default: ;
        endcase
    end

    word_byte_serializer #(
        .NB_WORD (NB_WORD),
        .NB_DATA (NB_DATA),
        .CNT_W   (CNT_W)
    ) u_ser (
        .clk_i    (i_clock),
        .rst_ni   (i_reset),
        .load_i   (ser_load),
        .word_i   (ser_word),
        .nbytes_i (ser_nbytes),
        .shift_i  (ser_shift),
        .byte_o   (ser_byte),
        .last_o   (ser_last)
    );

    // Dump sequencer: phases load words, SEND/WAIT drain them, ret_q picks the next phase.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            pc_q       <= '0;
            cyc_q      <= '0;
            idx_q      <= '0;
            ld_wait_q  <= 1'b0;
            o_reg_addr <= '0;
            o_mem_addr <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            case (state_q)
                S_IDLE: if (i_start) begin
                    pc_q    <= i_pc;
                    cyc_q   <= i_cycle_count;
                    o_busy  <= 1'b1;
                    state_q <= S_HDR;
                end
                S_HDR: begin
                    ret_q   <= S_PC;
                    state_q <= S_SEND;
                end
                S_PC: begin
                    ret_q   <= S_CYC;
                    state_q <= S_SEND;
                end
                S_CYC: begin
                    ret_q   <= S_REG_REQ;
                    state_q <= S_SEND;
                end
                S_REG_REQ: begin
                    o_reg_addr <= idx_q[NB_REG_ADDR-1:0];
                    state_q    <= S_REG_LD;
                end
                // Extra cycle lets a registered read port present its data.
                S_REG_LD: begin
                    ld_wait_q <= !ld_wait_q;
                    if (ld_wait_q) begin
                        state_q <= S_SEND;
                        if (idx_q == IDX_W'(N_REGS - 1)) begin
                            idx_q <= '0;
                            ret_q <= S_MEM_REQ;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            ret_q <= S_REG_REQ;
                        end
                    end
                end
                S_MEM_REQ: begin
                    o_mem_addr <= idx_q[NB_MEM_ADDR-1:0];
                    state_q    <= S_MEM_LD;
                end
                S_MEM_LD: begin
                    ld_wait_q <= !ld_wait_q;
                    if (ld_wait_q) begin
                        state_q <= S_SEND;
                        if (idx_q == IDX_W'(N_MEM_WORDS - 1)) begin
                            idx_q <= '0;
                            ret_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                            ret_q <= S_MEM_REQ;
                        end
                    end
                end
                S_SEND: begin
                    o_tx_start <= 1'b1;
                    o_tx_data  <= ser_byte;
                    state_q    <= S_WAIT;
                end
                S_WAIT: if (ser_shift) begin
                    if (!ser_last) begin
                        state_q <= S_SEND;
                    end else if (ret_q == S_DONE) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= ret_q;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Self-checking bench for debug_dump_tx: expected frame bytes are queued at
// start, a monitor pops them on every o_tx_start pulse.
module tb_debug_dump_tx;

    logic        clk;
    logic        i_reset, i_start, i_tx_done;
    logic [31:0] i_pc, i_cycle_count, i_reg_data, i_mem_data;
    logic [4:0]  o_reg_addr, o_mem_addr;
    logic [7:0]  o_tx_data;
    logic        o_tx_start, o_busy, o_done;

    debug_dump_tx dut (
        .i_clock       (clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_pc          (i_pc),
        .i_cycle_count (i_cycle_count),
        .o_reg_addr    (o_reg_addr),
        .i_reg_data    (i_reg_data),
        .o_mem_addr    (o_mem_addr),
        .i_mem_data    (i_mem_data),
        .o_tx_data     (o_tx_data),
        .o_tx_start    (o_tx_start),
        .i_tx_done     (i_tx_done),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors = 0;
    int errors  = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] regfile [32];
    logic [31:0] memory  [32];
    int  frame_pulses = 0;
    int  done_cnt     = 0;
    int  exp_done     = 0;
    bit  noise        = 0;
    bit  rand_lat     = 0;
    bit  tx_kill      = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference frame: header, PC and cycle MSB-first, then every register and memory word.
    task automatic push_frame(logic [31:0] pc, logic [31:0] cyc);
        exp_q.push_back(8'hD0);
        for (int b = 3; b >= 0; b--) exp_q.push_back(pc[b*8 +: 8]);
        for (int b = 3; b >= 0; b--) exp_q.push_back(cyc[b*8 +: 8]);
        for (int r = 0; r < 32; r++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(regfile[r][b*8 +: 8]);
        for (int m = 0; m < 32; m++)
            for (int b = 3; b >= 0; b--) exp_q.push_back(memory[m][b*8 +: 8]);
    endtask

    // Register file and data memory with one cycle of read latency.
    initial begin : read_ports
        logic [4:0] ra, ma;
        i_reg_data = '0;
        i_mem_data = '0;
        forever begin
            @(negedge clk);
            ra = o_reg_addr;
            ma = o_mem_addr;
            @(posedge clk);
            #1;
            i_reg_data = regfile[ra];
            i_mem_data = memory[ma];
        end
    end

    // UART TX model: acks each byte after a latency; in noisy mode also raises
    // done alongside o_tx_start and one cycle after a real ack.
    initial begin : tx_model
        int  cnt;
        bit  pend, stray;
        pend = 0; stray = 0; cnt = 0;
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (tx_kill) begin
                pend = 0;
                stray = 0;
            end else begin
                if (stray) begin
                    i_tx_done = 1'b1;
                    stray = 0;
                end
                if (o_tx_start) begin
                    cnt  = rand_lat ? int'($urandom_range(1, 5)) : 3;
                    pend = 1;
                    if (noise && $urandom_range(0, 2) == 0) i_tx_done = 1'b1;
                end else if (pend) begin
                    cnt--;
                    if (cnt == 0) begin
                        i_tx_done = 1'b1;
                        pend = 0;
                        if (noise && $urandom_range(0, 1) == 0) stray = 1;
                    end
                end
            end
        end
    end

    // Monitor: every o_tx_start pulse must carry the next expected byte.
    initial begin : monitor
        logic       prev_start;
        logic [7:0] e;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_start) begin
                frame_pulses++;
                check("tx_start_single_cycle", 32'(prev_start), 32'd0);
                if (exp_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL tx_extra_byte: got %h, expected no byte", o_tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", 32'(o_tx_data), 32'(e));
                end
            end
            if (o_done) done_cnt++;
            prev_start = o_tx_start;
        end
    end

    task automatic check_idle(string tag);
        check({tag, "_busy"},     32'(o_busy),     32'd0);
        check({tag, "_done"},     32'(o_done),     32'd0);
        check({tag, "_tx_start"}, 32'(o_tx_start), 32'd0);
        check({tag, "_tx_data"},  32'(o_tx_data),  32'd0);
        check({tag, "_reg_addr"}, 32'(o_reg_addr), 32'd0);
        check({tag, "_mem_addr"}, 32'(o_mem_addr), 32'd0);
    endtask

    // Issue a start in IDLE and check acceptance and first-byte latency.
    task automatic start_frame(logic [31:0] pc, logic [31:0] cyc);
        int n;
        push_frame(pc, cyc);
        frame_pulses = 0;
        i_pc = pc;
        i_cycle_count = cyc;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("busy_after_start", 32'(o_busy), 32'd1);
        n = 1;
        while (!o_tx_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("first_tx_start_latency", n, 3);
    endtask

    // Run until o_done, with optional start noise and input churn; returns at the done cycle.
    task automatic finish_frame();
        int cyc;
        cyc = 0;
        while (!o_done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (noise && !o_done) begin
                i_start       = ($urandom_range(0, 7) == 0);
                i_pc          = $urandom;
                i_cycle_count = $urandom;
            end
        end
        i_start = 1'b0;
        if (!o_done) begin
            vectors++;
            errors++;
            $display("FAIL frame_timeout: got no o_done, expected o_done within 20000 cycles");
        end
        exp_done++;
        check("busy_low_with_done", 32'(o_busy), 32'd0);
        check("frame_byte_count", frame_pulses, 265);
        check("queue_drained", exp_q.size(), 0);
        check("reg_addr_holds_last", 32'(o_reg_addr), 32'd31);
        check("mem_addr_holds_last", 32'(o_mem_addr), 32'd31);
    endtask

    task automatic randomize_state();
        for (int i = 0; i < 32; i++) begin
            regfile[i] = $urandom;
            memory[i]  = $urandom;
        end
    endtask

    initial begin : stimulus
        int n;
        i_reset = 1'b0;
        i_start = 1'b0;
        i_pc = '0;
        i_cycle_count = '0;
        for (int i = 0; i < 32; i++) begin
            regfile[i] = '0;
            memory[i]  = '0;
        end
        repeat (3) @(negedge clk);
        check_idle("reset");
        i_reset = 1'b1;
        repeat (2) @(negedge clk);

        // Frame 1: known contents, fixed 3-cycle ack.
        for (int i = 0; i < 32; i++) begin
            regfile[i] = 32'hA000_0000 + i;
            memory[i]  = $urandom;
        end
        memory[5] = 32'hDEAD_BEEF;
        start_frame(32'h0000_0040, 32'd17);
        finish_frame();
        @(negedge clk);
        check("done_count_f1", done_cnt, exp_done);

        // Frame 2: random contents, start noise, stray done pulses, random ack latency.
        noise = 1;
        rand_lat = 1;
        randomize_state();
        repeat (2) @(negedge clk);
        start_frame($urandom, $urandom);
        finish_frame();
        // Start during the o_done cycle must be ignored.
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("start_at_done_ignored", 32'(o_busy), 32'd0);
        check("done_count_f2", done_cnt, exp_done);

        // Frame 3: accepted from IDLE right after the ignored request.
        randomize_state();
        start_frame($urandom, $urandom);
        finish_frame();
        @(negedge clk);
        check("done_count_f3", done_cnt, exp_done);

        // Frame 4: reset while a byte is in flight.
        randomize_state();
        repeat (2) @(negedge clk);
        start_frame($urandom, $urandom);
        n = 1;
        while (n < 20) begin
            @(negedge clk);
            if (o_tx_start) n++;
        end
        i_reset = 1'b0;
        tx_kill = 1;
        @(negedge clk);
        check_idle("mid_wait_reset");
        exp_q.delete();
        i_reset = 1'b1;
        repeat (4) @(negedge clk);
        tx_kill = 0;
        check_idle("after_reset");
        check("done_count_f4", done_cnt, exp_done);

        // Frame 5: full random frame after the aborted one.
        randomize_state();
        start_frame($urandom, $urandom);
        finish_frame();
        repeat (4) @(negedge clk);
        check("done_count_f5", done_cnt, exp_done);
        check("idle_at_end", 32'(o_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
